// File: rtl/sockit_spi_slv_if.sv
// sockit SPI slave queue interface.
// Output queue (to MISO) and input queue (from MOSI) handshakes.
interface sockit_spi_slv_if #(
    parameter int SDW = 8
);
    logic           quo_vld;
    logic [SDW-1:0] quo_dat;
    logic           quo_rdy;
    logic           qui_vld;
    logic [1:0]     qui_ctl;
    logic [SDW-1:0] qui_dat;
    logic           qui_rdy;

    modport slave (
        input  quo_vld,
        input  quo_dat,
        output quo_rdy,
        output qui_vld,
        output qui_ctl,
        output qui_dat,
        input  qui_rdy
    );

    modport master (
        output quo_vld,
        output quo_dat,
        input  quo_rdy,
        input  qui_vld,
        input  qui_ctl,
        input  qui_dat,
        output qui_rdy
    );
endinterface

// File: rtl/sockit_spi_slv.sv
// sockit SPI slave: oversampled single-lane responder.
// MOSI words go to the input queue, output queue words go to MISO.
module sockit_spi_slv #(
    parameter int             SDW = 8,
    parameter int             SDL = 3,
    parameter int             SYN = 2,
    parameter logic [SDW-1:0] UNF = {SDW{1'b1}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       spi_cfg,
    sockit_spi_slv_if.slave   q,
    input  logic              spi_sclk_i,
    input  logic              spi_ss_i,
    input  logic [3:0]        spi_sio_i,
    output logic [3:0]        spi_sio_o,
    output logic [3:0]        spi_sio_e,
    output logic              err_ovf
);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic pha;
    logic pol;
    logic dir;

    logic [SYN-1:0] sclk_sy;
    logic [SYN-1:0] ss_sy;
    logic [SYN-1:0] mosi_sy;
    logic           sclk_d;
    logic           ss_d;
    logic           mosi;

    logic s_cur;
    logic s_prv;
    logic s_rise;
    logic s_fall;
    logic ss_rise;
    logic ss_fall;

    logic ld_start;
    logic smp;
    logic sft;
    logic drop;

    logic [SDW-1:0] tx_sr;
    logic [SDW-1:0] rx_sr;
    logic [SDW-1:0] rx_nxt;
    logic [SDL-1:0] bit_cnt;
    logic           first;
    logic           new_w;
    logic           unf_w;

    logic           wrap;
    logic           reload;
    logic           load;
    logic           pop;
    logic           push;

    logic           qui_vld_r;
    logic [1:0]     qui_ctl_r;
    logic [SDW-1:0] qui_dat_r;
    logic           miso;
    logic           sio_e1;

    logic unused;

    assign pha = spi_cfg[0];
    assign pol = spi_cfg[1];
    assign dir = spi_cfg[6];

    assign unused = ^{spi_cfg[31:7], spi_cfg[5:2],
                      spi_sio_i[3:1]};

    assign mosi = mosi_sy[SYN-1];

    // Normalized clock: rising is always the sample edge.
    assign s_cur   = sclk_sy[SYN-1] ^ pol ^ pha;
    assign s_prv   = sclk_d ^ pol ^ pha;
    assign s_rise  = s_cur & ~s_prv;
    assign s_fall  = ~s_cur & s_prv;
    assign ss_rise = ss_sy[SYN-1] & ~ss_d;
    assign ss_fall = ~ss_sy[SYN-1] & ss_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ss_rise) state_nxt = ACTIVE;
            ACTIVE:  if (ss_fall) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // SS fall wins over a serial clock edge seen on the same cycle.
    always_comb begin
        ld_start = 1'b0;
        smp      = 1'b0;
        sft      = 1'b0;
        drop     = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    ld_start = ss_rise;
                end
                ACTIVE: begin
                    drop = ss_fall;
                    smp  = s_rise & ~ss_fall;
                    sft  = s_fall & ~ss_fall;
                end
                default: ;
            endcase
        end
    end

    assign wrap   = smp && (bit_cnt == SDL'(SDW-1));
    assign reload = sft && !first && (bit_cnt == '0);
    assign load   = ld_start || reload;
    assign pop    = load && q.quo_vld;
    assign push   = wrap && (!qui_vld_r || q.qui_rdy);

    assign rx_nxt = dir ? {rx_sr[SDW-2:0], mosi}
                        : {mosi, rx_sr[SDW-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sy   <= '0;
            ss_sy     <= '0;
            mosi_sy   <= '0;
            sclk_d    <= 1'b0;
            ss_d      <= 1'b0;
            tx_sr     <= '0;
            rx_sr     <= '0;
            bit_cnt   <= '0;
            first     <= 1'b0;
            new_w     <= 1'b0;
            unf_w     <= 1'b0;
            qui_vld_r <= 1'b0;
            qui_ctl_r <= '0;
            qui_dat_r <= '0;
            miso      <= 1'b0;
            sio_e1    <= 1'b0;
            err_ovf   <= 1'b0;
        end else begin
            sclk_sy <= {sclk_sy[SYN-2:0], spi_sclk_i};
            ss_sy   <= {ss_sy[SYN-2:0], spi_ss_i};
            mosi_sy <= {mosi_sy[SYN-2:0], spi_sio_i[0]};
            sclk_d  <= sclk_sy[SYN-1];
            ss_d    <= ss_sy[SYN-1];
            err_ovf <= wrap && !push;

            if (load) begin
                tx_sr <= q.quo_vld ? q.quo_dat : UNF;
                unf_w <= !q.quo_vld;
            end else if (sft && !first) begin
                tx_sr <= dir ? (tx_sr << 1) : (tx_sr >> 1);
            end

            if (ld_start) begin
                bit_cnt <= '0;
                new_w   <= 1'b1;
                first   <= pha;
            end else if (drop) begin
                bit_cnt <= '0;
            end else begin
                if (smp) begin
                    bit_cnt <= wrap ? '0 : bit_cnt + 1'b1;
                end
                if (sft && first) begin
                    first <= 1'b0;
                end
            end

            if (smp) begin
                rx_sr <= rx_nxt;
            end

            // A full holding register drops the word and keeps new.
            if (push) begin
                qui_dat_r <= rx_nxt;
                qui_ctl_r <= {new_w, unf_w};
                qui_vld_r <= 1'b1;
                new_w     <= 1'b0;
            end else if (qui_vld_r && q.qui_rdy) begin
                qui_vld_r <= 1'b0;
            end

            if (state == ACTIVE) begin
                miso <= dir ? tx_sr[SDW-1] : tx_sr[0];
            end else begin
                miso <= 1'b0;
            end
            sio_e1 <= (state_nxt == ACTIVE);
        end
    end

    assign q.quo_rdy = pop;
    assign q.qui_vld = qui_vld_r;
    assign q.qui_ctl = qui_ctl_r;
    assign q.qui_dat = qui_dat_r;

    assign spi_sio_o = {2'b00, miso, 1'b0};
    assign spi_sio_e = {2'b00, sio_e1, 1'b0};

endmodule

// File: tb/tb_sockit_spi_slv.sv
// Bench for sockit_spi_slv: bit-banged SPI master,
// queue feeder and scoreboards for MISO and received words.
module tb_sockit_spi_slv;

    localparam int H = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] spi_cfg;
    logic        sclk;
    logic        ss;
    logic        mosi;
    logic [3:0]  sio_o;
    logic [3:0]  sio_e;
    logic        err_ovf;

    int n_chk = 0;
    int n_err = 0;
    int rdy_cnt = 0;
    int ovf_cnt = 0;
    bit pend = 1'b0;

    logic [7:0] txq[$];
    logic [7:0] misoq[$];
    logic [9:0] quiq[$];

    always #5 clk = ~clk;

    sockit_spi_slv_if #(.SDW(8)) qif ();

    sockit_spi_slv dut (
        .clk        (clk),
        .rst        (rst),
        .spi_cfg    (spi_cfg),
        .q          (qif),
        .spi_sclk_i (sclk),
        .spi_ss_i   (ss),
        .spi_sio_i  ({3'b000, mosi}),
        .spi_sio_o  (sio_o),
        .spi_sio_e  (sio_e),
        .err_ovf    (err_ovf)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h",
                     tag, got, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_mode(input logic [31:0] c);
        spi_cfg = c;
        sclk = c[1];
        clks(8);
    endtask

    task automatic ss_on();
        ss = 1'b1;
        clks(8);
    endtask

    task automatic ss_off();
        ss = 1'b0;
        clks(8);
    endtask

    // One master word; MISO captured on each sample edge.
    task automatic spi_word(input logic [7:0] w,
                            input int nb,
                            input bit chk);
        logic [7:0] r;
        logic [7:0] e;
        int bi;
        r = '0;
        if (!spi_cfg[0]) begin
            mosi = spi_cfg[6] ? w[7] : w[0];
            clks(H);
        end
        for (int i = 0; i < nb; i++) begin
            bi = spi_cfg[6] ? 7 - i : i;
            if (!spi_cfg[0]) begin
                r[bi] = sio_o[1];
                sclk = ~sclk;
                clks(H);
                sclk = ~sclk;
                if (i + 1 < 8) begin
                    mosi = spi_cfg[6] ? w[6-i] : w[i+1];
                end
                clks(H);
            end else begin
                sclk = ~sclk;
                mosi = w[bi];
                clks(H);
                r[bi] = sio_o[1];
                sclk = ~sclk;
                clks(H);
            end
        end
        if (chk) begin
            if (misoq.size() == 0) begin
                check("miso_extra", misoq.size(), 1);
            end else begin
                e = misoq.pop_front();
                check("miso_word", r, e);
            end
        end
    endtask

    // Output queue model: pop when the DUT strobes quo_rdy.
    initial begin
        logic [7:0] d;
        forever begin
            @(negedge clk);
            if (pend) d = txq.pop_front();
            qif.quo_vld = (txq.size() > 0);
            qif.quo_dat = (txq.size() > 0) ? txq[0] : 8'h00;
            #3;
            pend = qif.quo_rdy;
            if (pend) rdy_cnt++;
        end
    end

    // Input queue monitor.
    initial begin
        logic [9:0] e;
        forever begin
            @(negedge clk);
            #3;
            if (err_ovf) ovf_cnt++;
            if (qif.qui_vld && qif.qui_rdy) begin
                if (quiq.size() == 0) begin
                    check("qui_extra", quiq.size(), 1);
                end else begin
                    e = quiq.pop_front();
                    check("qui_word",
                          {qif.qui_ctl, qif.qui_dat}, e);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        spi_cfg = 32'h40;
        sclk = 1'b0;
        ss = 1'b0;
        mosi = 1'b0;
        qif.quo_vld = 1'b0;
        qif.quo_dat = 8'h00;
        qif.qui_rdy = 1'b1;
        clks(3);
        check("rst_quo_rdy", qif.quo_rdy, 0);
        check("rst_qui",
              {qif.qui_vld, qif.qui_ctl, qif.qui_dat}, 0);
        check("rst_pads", {sio_o, sio_e, err_ovf}, 0);
        rst = 1'b0;
        clks(4);

        // mode 0, MSB first
        set_mode(32'h40);
        txq.push_back(8'h3C);
        misoq.push_back(8'h3C);
        quiq.push_back({2'b10, 8'hA5});
        clks(2);
        ss_on();
        spi_word(8'hA5, 8, 1);
        ss_off();
        check("t1_rdy", rdy_cnt, 1);

        // mode 3, LSB first, two words per select
        set_mode(32'h03);
        txq.push_back(8'h5A);
        txq.push_back(8'hC3);
        misoq.push_back(8'h5A);
        misoq.push_back(8'hC3);
        quiq.push_back({2'b10, 8'h11});
        quiq.push_back({2'b00, 8'h22});
        clks(2);
        ss_on();
        spi_word(8'h11, 8, 1);
        spi_word(8'h22, 8, 1);
        ss_off();
        check("t2_rdy", rdy_cnt, 3);

        // empty output queue sends underflow word
        set_mode(32'h40);
        misoq.push_back(8'hFF);
        quiq.push_back({2'b11, 8'h0F});
        ss_on();
        spi_word(8'h0F, 8, 1);
        ss_off();
        check("t3_rdy", rdy_cnt, 3);

        // overflow while the input queue stalls
        qif.qui_rdy = 1'b0;
        misoq.push_back(8'hFF);
        misoq.push_back(8'hFF);
        quiq.push_back({2'b11, 8'h01});
        ss_on();
        spi_word(8'h01, 8, 1);
        spi_word(8'h02, 8, 1);
        ss_off();
        check("t4_ovf", ovf_cnt, 1);
        check("t4_hold", qif.qui_dat, 8'h01);
        check("t4_vld", qif.qui_vld, 1);
        qif.qui_rdy = 1'b1;
        clks(3);
        check("t4_drain", quiq.size(), 0);

        // select dropped mid-word
        misoq.push_back(8'hFF);
        quiq.push_back({2'b11, 8'h81});
        ss_on();
        spi_word(8'hFF, 5, 0);
        ss_off();
        ss_on();
        spi_word(8'h81, 8, 1);
        ss_off();

        // reset mid-word with the clock moving
        qif.qui_rdy = 1'b0;
        misoq.push_back(8'hFF);
        ss_on();
        spi_word(8'h5E, 8, 1);
        spi_word(8'h00, 3, 0);
        check("t6_pre", {qif.qui_vld, qif.qui_dat}, 9'h15E);
        rst = 1'b1;
        ss = 1'b0;
        sclk = ~sclk;
        clks(1);
        check("t6_rst",
              {qif.quo_rdy, qif.qui_vld, qif.qui_ctl,
               qif.qui_dat, sio_o, sio_e, err_ovf}, 0);
        sclk = ~sclk;
        clks(2);
        rst = 1'b0;
        sclk = spi_cfg[1];
        qif.qui_rdy = 1'b1;
        clks(10);
        check("t6_idle", sio_e, 0);
        check("t6_ovf", ovf_cnt, 1);
        misoq.push_back(8'hFF);
        quiq.push_back({2'b11, 8'h42});
        ss_on();
        check("t6_act", sio_e, 4'b0010);
        spi_word(8'h42, 8, 1);
        ss_off();
        clks(5);

        check("sb_qui", quiq.size(), 0);
        check("sb_miso", misoq.size(), 0);
        check("quo_rdy_total", rdy_cnt, 3);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule
